// File: rtl/ysyx_22050854_imm_encoder_if.sv
// Request/response bus of the immediate encoder: a valid/ready request side
// carrying {extop, imm, base} and a valid/ready result side carrying the word.
interface ysyx_22050854_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_extop;
  logic [63:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport slave (
    input  in_valid, in_extop, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, in_extop, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/ysyx_22050854_imm_encoder.sv
// Packs a 64-bit immediate into the RV64 I/U/S/B/J immediate fields of a base
// instruction word; two-stage valid/ready pipeline with legality checking.
module ysyx_22050854_imm_encoder #(
  parameter int ERR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22050854_imm_encoder_if.slave bus,
  output logic [ERR_W-1:0]          err_cnt
);

  localparam logic [2:0] OP_I = 3'b000;
  localparam logic [2:0] OP_U = 3'b001;
  localparam logic [2:0] OP_S = 3'b010;
  localparam logic [2:0] OP_B = 3'b011;
  localparam logic [2:0] OP_J = 3'b100;

  // True when every bit from msb upward equals bit msb, i.e. v is a sign
  // extension of its low msb+1 bits.
  function automatic logic fits(input logic signed [63:0] v, input int unsigned msb);
    logic signed [63:0] sh;
    sh = v >>> msb;
    return (sh == 64'sd0) || (sh == -64'sd1);
  endfunction

  function automatic logic imm_illegal(input logic [2:0] op, input logic signed [63:0] v);
    case (op)
      OP_I, OP_S: imm_illegal = !fits(v, 11);
      OP_U:       imm_illegal = (v[11:0] != 12'h000) || !fits(v, 31);
      OP_B:       imm_illegal = v[0] || !fits(v, 12);
      OP_J:       imm_illegal = v[0] || !fits(v, 20);
      default:    imm_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic [2:0] op, input logic signed [63:0] v,
                                       input logic [31:0] b);
    case (op)
      OP_I:    pack = {v[11:0], b[19:0]};
      OP_U:    pack = {v[31:12], b[11:0]};
      OP_S:    pack = {v[11:5], b[24:12], v[4:0], b[6:0]};
      OP_B:    pack = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
      OP_J:    pack = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
      default: pack = b;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  logic               vld_p1;
  logic [2:0]         extop_p1;
  logic signed [63:0] imm_p1;
  logic [31:0]        base_p1;
  logic               err_p1;

  logic               vld_p2;
  logic [31:0]        instr_p2;
  logic               err_p2;

  logic               s2_free;
  logic               accept;

  assign s2_free      = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !vld_p1 || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- stage 1: capture request, evaluate legality ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (bus.in_ready) begin
      vld_p1 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      extop_p1 <= bus.in_extop;
      imm_p1   <= $signed(bus.in_imm);
      base_p1  <= bus.in_base;
      err_p1   <= imm_illegal(bus.in_extop, $signed(bus.in_imm));
    end
  end

  // ---- stage 2: merged instruction held until taken ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= err_p1 ? base_p1 : pack(extop_p1, imm_p1, base_p1);
        err_p2   <= err_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (vld_p2 && bus.out_ready && err_p2) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_instr = instr_p2;
  assign bus.out_err   = err_p2;

endmodule

// File: tb/tb_ysyx_22050854_imm_encoder.sv
// Bench for the immediate encoder: directed vectors, backpressure, reset and a
// randomized stream checked against an arithmetic model and an imm_gen decoder.
module tb_ysyx_22050854_imm_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] err_cnt0;
  logic [1:0] err_cnt1;

  ysyx_22050854_imm_encoder_if if0 ();
  ysyx_22050854_imm_encoder_if if1 ();

  ysyx_22050854_imm_encoder #(.ERR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (if0.slave),
    .err_cnt (err_cnt0)
  );

  ysyx_22050854_imm_encoder #(.ERR_W(2)) dut_small (
    .clk     (clk),
    .rst     (rst),
    .bus     (if1.slave),
    .err_cnt (err_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  op;
    logic [63:0] imm;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_errs   = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [2:0] op, input logic [63:0] imm);
    longint s;
    s = longint'(imm);
    case (op)
      3'd0, 3'd2: return (s < -64'sd2048) || (s > 64'sd2047);
      3'd1:       return (s % 4096 != 0) || (s < -64'sd2147483648) || (s > 64'sd2147483647);
      3'd3:       return (s % 2 != 0) || (s < -64'sd4096) || (s > 64'sd4095);
      3'd4:       return (s % 2 != 0) || (s < -64'sd1048576) || (s > 64'sd1048575);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_instr(input logic [2:0] op, input logic [63:0] imm,
                                              input logic [31:0] base);
    logic [63:0] b, r;
    b = {32'h0, base};
    if (model_err(op, imm)) return base;
    case (op)
      3'd0: r = (b & 64'h000F_FFFF) | ((imm & 64'hFFF) << 20);
      3'd1: r = (b & 64'hFFF) | (imm & 64'hFFFF_F000);
      3'd2: r = (b & 64'h01FF_F07F) | (((imm >> 5) & 64'h7F) << 25) | ((imm & 64'h1F) << 7);
      3'd3: r = (b & 64'h01FF_F07F) | (((imm >> 12) & 64'h1) << 31)
              | (((imm >> 5) & 64'h3F) << 25) | (((imm >> 1) & 64'hF) << 8)
              | (((imm >> 11) & 64'h1) << 7);
      3'd4: r = (b & 64'hFFF) | (((imm >> 20) & 64'h1) << 31)
              | (((imm >> 1) & 64'h3FF) << 21) | (((imm >> 11) & 64'h1) << 20)
              | (((imm >> 12) & 64'hFF) << 12);
      default: r = b;
    endcase
    return r[31:0];
  endfunction

  // Standard RV64 immediate generator, used to confirm the round trip.
  function automatic logic [63:0] imm_dec(input logic [31:0] x, input logic [2:0] op);
    case (op)
      3'd0:    return {{52{x[31]}}, x[31:20]};
      3'd1:    return {{32{x[31]}}, x[31:12], 12'h000};
      3'd2:    return {{52{x[31]}}, x[31:25], x[11:7]};
      3'd3:    return {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd4:    return {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] rand_imm();
    logic signed [12:0] t13;
    logic signed [21:0] t22;
    logic [19:0]        h;
    logic [63:0]        v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: begin t13 = 13'($urandom); v = {{51{t13[12]}}, t13}; end
      2: begin t22 = 22'($urandom); v = {{42{t22[21]}}, t22}; end
      default: begin
        h = 20'($urandom);
        v = {{32{h[19]}}, h, 12'h000};
        if ($urandom_range(0, 3) == 0) v[0] = 1'b1;
      end
    endcase
    return v;
  endfunction

  // One clock of traffic: drive at negedge, score handshakes just before the
  // rising edge, check the error counter just after it.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [63:0] imm,
                       input logic [31:0] base, input logic rdy, output logic acc);
    exp_t e;
    @(negedge clk);
    if0.in_valid  = v;
    if0.in_extop  = op;
    if0.in_imm    = imm;
    if0.in_base   = base;
    if0.out_ready = rdy;
    #1;
    if (hold_chk) begin
      chk("hold_valid", 64'(if0.out_valid), 64'd1);
      chk("hold_instr", 64'(if0.out_instr), 64'(held_instr));
      chk("hold_err", 64'(if0.out_err), 64'(held_err));
    end
    chk("in_ready", 64'(if0.in_ready), 64'((q.size() < 2) || rdy));
    acc = v && if0.in_ready;
    if (if0.out_valid && rdy) begin
      n_assert++;
      assert (q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL out_queue: observed output %h with no request outstanding", if0.out_instr);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_instr", 64'(if0.out_instr), 64'(e.instr));
        chk("out_err", 64'(if0.out_err), 64'(e.err));
        if (!e.err) chk("round_trip", imm_dec(if0.out_instr, e.op), e.imm);
        if (e.err && m_errs < 255) m_errs++;
      end
    end
    if (acc) begin
      e.instr = model_instr(op, imm, base);
      e.err   = model_err(op, imm);
      e.op    = op;
      e.imm   = imm;
      q.push_back(e);
    end
    hold_chk   = if0.out_valid && !rdy;
    held_instr = if0.out_instr;
    held_err   = if0.out_err;
    @(posedge clk);
    #1;
    chk("err_cnt", 64'(err_cnt0), 64'(m_errs));
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [63:0] imm,
                          input logic [31:0] base, input logic [31:0] exp_instr,
                          input logic exp_err);
    logic acc;
    cycle(1'b1, op, imm, base, 1'b1, acc);
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    chk({tag, "_lat1"}, 64'(if0.out_valid), 64'd0);
    cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, acc);
    chk({tag, "_lat2"}, 64'(if0.out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(if0.out_instr), 64'(exp_instr));
    chk({tag, "_err"}, 64'(if0.out_err), 64'(exp_err));
    cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, acc);
    chk({tag, "_drain"}, 64'(if0.out_valid), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic        pv;
    logic [2:0]  pop;
    logic [63:0] pimm;
    logic [31:0] pbase;
    int          k;
    int          r;

    rst = 1'b0;
    if0.in_valid = 1'b0; if0.in_extop = '0; if0.in_imm = '0; if0.in_base = '0;
    if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_extop = '0; if1.in_imm = '0; if1.in_base = '0;
    if1.out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_out_instr", 64'(if0.out_instr), 64'd0);
    chk("rst_out_err", 64'(if0.out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt0), 64'd0);
    chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
    chk("rst_err_cnt_small", 64'(err_cnt1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    directed("I_neg1", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    directed("U_ok", 3'd1, 64'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    directed("U_mis", 3'd1, 64'h1234_5001, 32'h0000_02B7, 32'h0000_02B7, 1'b1);
    directed("S_8", 3'd2, 64'd8, 32'h0020_A023, 32'h0020_A423, 1'b0);
    directed("B_m4", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    directed("J_800", 3'd4, 64'h800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    directed("J_rng", 3'd4, 64'h10_0000, 32'h0000_006F, 32'h0000_006F, 1'b1);
    directed("op101", 3'd5, 64'd0, 32'h0000_0013, 32'h0000_0013, 1'b1);
    directed("I_max", 3'd0, 64'd2047, 32'h0000_0013, 32'h7FF0_0013, 1'b0);
    directed("I_over", 3'd0, 64'd2048, 32'h0000_0013, 32'h0000_0013, 1'b1);

    // Backpressure: out_ready low for the first three cycles of a 4-request burst.
    cycle(1'b1, 3'd0, 64'd1, 32'h0000_0013, 1'b0, acc);
    chk("bp_acc0", 64'(acc), 64'd1);
    cycle(1'b1, 3'd2, 64'd4, 32'h0000_2023, 1'b0, acc);
    chk("bp_acc1", 64'(acc), 64'd1);
    cycle(1'b1, 3'd3, 64'd8, 32'h0000_0063, 1'b0, acc);
    chk("bp_stall", 64'(acc), 64'd0);
    k = 2;
    for (int i = 0; i < 10 && k < 4; i++) begin
      if (k == 2) cycle(1'b1, 3'd3, 64'd8, 32'h0000_0063, 1'b1, acc);
      else        cycle(1'b1, 3'd4, 64'd2, 32'h0000_006F, 1'b1, acc);
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd4);
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, acc);
    chk("bp_delivered", 64'(q.size()), 64'd0);

    // Reset with both stages occupied.
    cycle(1'b1, 3'd5, 64'd0, 32'h1, 1'b0, acc);
    cycle(1'b1, 3'd6, 64'd0, 32'h2, 1'b0, acc);
    chk("fill_valid", 64'(if0.out_valid), 64'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(if0.in_ready), 64'd1);
    chk("mid_rst_err_cnt", 64'(err_cnt0), 64'd0);
    q.delete();
    m_errs   = 0;
    hold_chk = 1'b0;
    @(negedge clk) rst = 1'b0;
    cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, acc);
    chk("post_rst_out_valid", 64'(if0.out_valid), 64'd0);

    // Randomized stream with random backpressure; requests held until accepted.
    pv = 1'b0; pop = '0; pimm = '0; pbase = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv    = 1'b1;
        r     = $urandom_range(0, 15);
        pop   = (r < 13) ? 3'(r % 5) : 3'(r - 8);
        pimm  = rand_imm();
        pbase = $urandom;
      end
      cycle(pv, pop, pimm, pbase, $urandom_range(0, 9) < 7, acc);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, acc);
    chk("rand_drained", 64'(q.size()), 64'd0);

    // Narrow counter saturates after five error results.
    if1.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.in_extop = 3'(5 + i % 3);
      if1.in_imm   = 64'(i);
      if1.in_base  = 32'h0000_0013;
      #1 chk("small_ready", 64'(if1.in_ready), 64'd1);
    end
    @(negedge clk) if1.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("small_err_sat", 64'(err_cnt1), 64'd3);
    chk("small_idle", 64'(if1.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
